alu_rr_arbiter: RTL and testbench

//  Shares one N-bit ALU instance between two requesters (e.g. EX-stage and a

---
 rtl/alu_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Shares one N-bit ALU between two valid/ready requesters, one operation in flight.
// Arbitration is round-robin unless ALU_ARB_FIXED_PRIO_EN is defined (port 0 wins ties).

module alu_rr_arbiter_alu #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic [N-1:0] alu_output,
  output logic         zero_flag,
  output logic         carry_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic [N:0] sum_add;
  logic [N:0] sum_sub;

  always_comb begin
    sum_add = {1'b0, a} + {1'b0, b};
    sum_sub = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    // Carry reports the A+B adder for every op except subtract (carry=1 means no borrow).
    carry_out  = sum_add[N];
    alu_output = '0;
    case (sel)
      OP_ADD: alu_output = sum_add[N-1:0];
      OP_SUB: begin
        alu_output = sum_sub[N-1:0];
        carry_out  = sum_sub[N];
      end
      OP_AND:  alu_output = a & b;
      OP_OR:   alu_output = a | b;
      default: alu_output = '0;
    endcase
    zero_flag = (alu_output == '0);
  end

endmodule

module alu_rr_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_sel0,
  input  logic [3:0]   req_sel1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_carry
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   sel_q, sel_d;
  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         rsp_carry_q, rsp_carry_d;

  logic         grant;
  logic [N-1:0] alu_output;
  logic         alu_zero;
  logic         alu_carry;

  // The ALU only ever sees the latched operands, so requesters may change inputs after acceptance.
  alu_rr_arbiter_alu #(.N(N)) u_alu (
    .a          (a_q),
    .b          (b_q),
    .sel        (sel_q),
    .alu_output (alu_output),
    .zero_flag  (alu_zero),
    .carry_out  (alu_carry)
  );

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          owner_d      = grant;
          last_grant_d = grant;
          a_d          = grant ? req_a1   : req_a0;
          b_d          = grant ? req_b1   : req_b0;
          sel_d        = grant ? req_sel1 : req_sel0;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_output;
        rsp_zero_d   = alu_zero;
        rsp_carry_d  = alu_carry;
        rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand registers are plain flops, not a RAM, so they can and do take a reset value.
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;

  a_rsp_valid_onehot : assert property (@(posedge clk) disable iff (!rst_n) rsp_valid_q != 2'b11);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: a cycle-level behavioural model compared every
// cycle, plus directed operations with hand-computed results.
module tb_alu_rr_arbiter;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [N-1:0]  req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [3:0]    req_sel0 = '0, req_sel1 = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b00;
  logic [N-1:0]  rsp_result;
  logic          rsp_zero, rsp_carry;

  int n_cmp = 0;
  int n_fail = 0;

  alu_rr_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .req_sel0   (req_sel0),
    .req_sel1   (req_sel1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain arithmetic: carry of add is overflow past 2^32, sub carry means a>=b.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                                  output logic [31:0] r, output bit z, output bit c);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(b);
    bit c_add = (la + lb) > 64'hFFFF_FFFF;
    case (s)
      4'b0010: begin r = a + b; c = c_add;    end
      4'b0110: begin r = a - b; c = (a >= b); end
      4'b0000: begin r = a & b; c = c_add;    end
      4'b0001: begin r = a | b; c = c_add;    end
      default: begin r = '0;    c = c_add;    end
    endcase
    z = (r == 0);
  endfunction

  // Behavioural model: idle / computing / responding, plus the last port served.
  bit          m_live = 0, m_busy = 0, m_resp = 0, m_owner = 0, m_last = 1;
  logic [31:0] m_res = 0, p_res = 0;
  bit          m_zero = 0, m_carry = 0, p_zero = 0, p_carry = 0;
  bit          m_g;

  function automatic bit pick();
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (req_valid == 2'b11) return 1'b0;
`else
    if (req_valid == 2'b11) return !m_last;
`endif
    return req_valid[1];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1; m_busy = 0; m_resp = 0; m_last = 1;
      m_res = 0; m_zero = 0; m_carry = 0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_g = pick();
        m_owner = m_g; m_last = m_g; m_busy = 1; m_resp = 0;
        ref_alu(m_g ? req_a1 : req_a0, m_g ? req_b1 : req_b0, m_g ? req_sel1 : req_sel0,
                p_res, p_zero, p_carry);
      end
    end else if (!m_resp) begin
      m_res = p_res; m_zero = p_zero; m_carry = p_carry; m_resp = 1;
    end else if (rsp_ready[m_owner]) begin
      m_busy = 0; m_resp = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_req_ready", req_ready,
            (rst_n && !m_busy && req_valid != 2'b00) ? (pick() ? 2'b10 : 2'b01) : 2'b00);
      check("model_rsp_valid", rsp_valid, (m_busy && m_resp) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      check("model_rsp_result", rsp_result, m_res);
      check("model_rsp_zero", rsp_zero, m_zero);
      check("model_rsp_carry", rsp_carry, m_carry);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
  endtask

  // One complete operation on port p with rsp_ready pre-set, checked against literals.
  task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                       input logic [31:0] er, input bit ez, input bit ec, input string tag);
    logic [1:0] oh = (p == 1) ? 2'b10 : 2'b01;
    int k = 0;
    step();
    if (p == 1) begin req_a1 = a; req_b1 = b; req_sel1 = s; end
    else        begin req_a0 = a; req_b0 = b; req_sel0 = s; end
    req_valid[p] = 1'b1;
    rsp_ready[p] = 1'b1;
    do begin @(negedge clk); k++; end while (!req_ready[p] && k < 20);
    check({tag, "_req_ready"}, req_ready, oh);
    step();
    req_valid[p] = 1'b0;
    @(negedge clk);
    check({tag, "_exec_rsp_valid"}, rsp_valid, 2'b00);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, oh);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_zero"}, rsp_zero, ez);
    check({tag, "_carry"}, rsp_carry, ec);
    step();
    rsp_ready[p] = 1'b0;
  endtask

  int g_port[$];
  int g_cyc[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b11;
    @(negedge clk);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_result", rsp_result, 32'd0);
    step(); req_valid = 2'b00; rst_n = 1'b1;

    do_op(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, "add_5_7");
    do_op(1, 32'd3, 32'd3, 4'b0110, 32'd0, 1'b1, 1'b1, "sub_3_3");
    do_op(1, 32'd3, 32'd4, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_3_4");
    do_op(0, 32'd9, 32'd9, 4'b1111, 32'd0, 1'b1, 1'b0, "illegal_sel");
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b1, "add_wrap");
    do_op(1, 32'hFFFF_0000, 32'hF0F0_F0F0, 4'b0000, 32'hF0F0_0000, 1'b0, 1'b1, "and_carry");

    // Continuous contention from reset: grant order and one accept every 3 cycles.
    do_reset();
    req_a0 = 32'd10; req_b0 = 32'd1; req_sel0 = 4'b0010;
    req_a1 = 32'd20; req_b1 = 32'd4; req_sel1 = 4'b0110;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin g_port.push_back(int'(req_ready[1])); g_cyc.push_back(c); end
    end
    check("rr_accept_count", g_port.size(), 4);
    while (g_port.size() < 4) begin g_port.push_back(-1); g_cyc.push_back(-100); end
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check($sformatf("grant_%0d", i), g_port[i], 0);
`else
      check($sformatf("grant_%0d", i), g_port[i], i % 2);
`endif
      if (i > 0) check($sformatf("accept_gap_%0d", i), g_cyc[i] - g_cyc[i-1], 3);
    end
    step(); req_valid = 2'b00;
    repeat (3) step();
    rsp_ready = 2'b00;

    // Response held under backpressure; the waiting port is served one cycle after the handshake.
    step();
    req_a0 = 32'hF0; req_b0 = 32'h0F; req_sel0 = 4'b0001; req_valid = 2'b01;
    @(negedge clk);
    check("bp_req_ready0", req_ready, 2'b01);
    step();
    req_valid = 2'b10; req_a1 = 32'd1; req_b1 = 32'd1; req_sel1 = 4'b0010;
    req_a0 = 32'h1234; req_b0 = 32'h5678;
    @(negedge clk);
    check("bp_exec_req_ready", req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid_%0d", i), rsp_valid, 2'b01);
      check($sformatf("bp_hold_result_%0d", i), rsp_result, 32'hFF);
      check($sformatf("bp_hold_req_ready_%0d", i), req_ready, 2'b00);
    end
    step(); rsp_ready = 2'b10;
    @(negedge clk);
    check("bp_nonowner_ignored", rsp_valid, 2'b01);
    step(); rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_last_valid", rsp_valid, 2'b01);
    step(); rsp_ready = 2'b00;
    @(negedge clk);
    check("bp_port1_ready", req_ready, 2'b10);
    step(); req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("bp_port1_valid", rsp_valid, 2'b10);
    check("bp_port1_result", rsp_result, 32'd2);
    step(); rsp_ready = 2'b00;

    // Reset during EXEC aborts the op and restores the port-0-first tie break.
    step();
    req_a0 = 32'd1; req_b0 = 32'd2; req_sel0 = 4'b0010; req_valid = 2'b01; rsp_ready = 2'b01;
    @(negedge clk);
    check("abort_req_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("abort_rsp_valid", rsp_valid, 2'b00);
    check("abort_result_cleared", rsp_result, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_response", rsp_valid, 2'b00);
    end
    step(); req_valid = 2'b11; rsp_ready = 2'b00;
    @(negedge clk);
    check("post_reset_grant", req_ready, 2'b01);
    step(); req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
